single_accumulator: RTL
=======================

# single_accumulator

Downstream stage of the integer block multiplier datapath. Consumes the stream of signed w-bit products from the single multiplier over the stb/ack handshake. Sums each group of n consecutive accepted products into one signed aw-bit dot-product element with a sticky overflow flag. Presents that element on an output stb/ack port for the block-result writer.

## Interface
- w, 8, width of each incoming signed product
- n, 4, products summed per result; n >= 1
- aw, 16, accumulator/result width; aw >= w
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-low reset (sampled on clk rising edge; 0 = reset)
- input_z  input  w  signed product from multiplier
- input_z_stb  input  1  input_z valid
- input_z_ack  output  1  accumulator ready; registered
- output_sum  output  aw  signed dot-product result; registered
- output_sum_stb  output  1  output_sum valid; registered
- output_sum_ack  input  1  consumer accepts output_sum
- output_ovf  output  1  signed overflow occurred in the group producing output_sum; registered

## Operation
- Internal state: acc[aw-1:0], cnt (0..n-1, width max(1, clog2(n))), ovf_acc, state ∈ {ACCUM, OUTPUT}.
- Input transfer: a rising edge where input_z_stb=1 and input_z_ack=1. No other cycle changes acc or cnt.
- Term: sext(input_z) to aw bits. Next sum = acc + term, modulo 2^aw (two's-complement wrap).
- Overflow of one add: acc and term have the same sign and the next sum's sign differs. ovf_acc ORs this over the group.
- ACCUM state: input_z_ack=1, output_sum_stb=0.
  - Transfer with cnt < n-1: acc <= next sum; cnt <= cnt+1; ovf_acc updated.
  - Transfer with cnt == n-1:
    - output_sum <= next sum; output_ovf <= ovf_acc | this add's overflow; output_sum_stb <= 1.
    - input_z_ack <= 0; acc <= 0; cnt <= 0; ovf_acc <= 0; state <= OUTPUT.
- OUTPUT state: input_z_ack=0, so input_z and input_z_stb are ignored. output_sum and output_ovf are held stable.
  - Edge with output_sum_ack=1: output_sum_stb <= 0; input_z_ack <= 1; state <= ACCUM.
  - output_sum, output_ovf keep their last value until the next result is loaded.
- n=1: every accepted product is emitted directly as its sext value. output_ovf is always 0.
- Reset (rst=0 at an edge), from any state including mid-group or mid-OUTPUT:
  - acc=0, cnt=0, ovf_acc=0, state=ACCUM.
  - output_sum=0, output_ovf=0, output_sum_stb=0, input_z_ack=0.
  - The partial group is discarded. A pending result is dropped.
  - input_z_ack rises to 1 on the first edge with rst=1.

## Timing
- input_z_ack is 0 during reset and 1 starting one cycle after reset is released.
- Result latency: output_sum_stb is high the cycle after the edge that accepted the n-th term.
- Minimum period per result is n+1 cycles: n accept cycles plus one OUTPUT cycle when output_sum_ack is already high.
- Any stb gap stalls accumulation without losing state. cnt counts transfers only.
- Backpressure: output_sum_stb stays high and input_z_ack stays low for as many cycles as output_sum_ack is low. There is no limit.
- output_sum_ack while output_sum_stb=0 has no effect.
- The output and input handshakes are never active in the same cycle. There is a single result buffer and no overlap.

## Test plan
- w=8, n=4, aw=16; products 3, -5, 10, 7 on consecutive cycles, output_sum_ack=1 -> output_sum=0x000F, output_ovf=0, stb high exactly one cycle. The cycle after that, input_z_ack=1.
- Same config; products -128, -128, -128, -128 with stb low every other cycle -> output_sum=0xFE00 (-512) after the 4th accepted term. Values presented while stb=0 are not summed.
- Backpressure: after a result, hold output_sum_ack=0 for 5 cycles while driving input_z=99, stb=1.
  - output_sum stays stable, stb=1, input_z_ack=0, and the 99s are ignored.
  - The next group 1,1,1,1 yields 0x0004.
- Overflow: w=8, n=4, aw=8; products 100, 100, 0, 0 -> output_sum=0xC8, output_ovf=1. The next group 1,2,3,4 -> 0x0A, output_ovf=0.
- Reset mid-group: accept 50, 60, then rst=0 for one cycle.
  - All outputs are 0 and input_z_ack=0 during reset; ack=1 one cycle after release.
  - The next group 1,1,1,1 -> 0x0004.
  - Repeat with reset asserted during OUTPUT: stb drops, result lost.
- n=1: products 5, -1 -> output_sum 0x0005 then 0xFFFF. Each is followed by one non-accepting OUTPUT cycle with output_sum_ack=1.

Source files
------------

// File: rtl/single_accumulator.sv
// single_accumulator: sums each group of n signed products into one
// signed aw-bit result with a sticky overflow flag. A single result
// buffer sits behind an stb/ack output port. While a result is pending,
// the input is not accepted.
module single_accumulator #(
  parameter int w  = 8,   // incoming product width
  parameter int n  = 4,   // products summed per result (n >= 1)
  parameter int aw = 16   // accumulator / result width (aw >= w)
) (
  input  logic                 clk,
  input  logic                 rst,            // synchronous, active-low
  input  logic signed [w-1:0]  input_z,
  input  logic                 input_z_stb,
  output logic                 input_z_ack,
  output logic signed [aw-1:0] output_sum,
  output logic                 output_sum_stb,
  input  logic                 output_sum_ack,
  output logic                 output_ovf
);

  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(n - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  // Sign-extend a product to accumulator width.
  function automatic logic signed [aw-1:0] sext_term(input logic signed [w-1:0] z);
    return aw'(z);
  endfunction

  // Two's-complement add overflow: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic signed [aw-1:0] a,
                                   input logic signed [aw-1:0] b,
                                   input logic signed [aw-1:0] s);
    return (a[aw-1] == b[aw-1]) && (s[aw-1] != a[aw-1]);
  endfunction

  state_t                 state_q, state_d;
  logic signed [aw-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic signed [aw-1:0]   sum_q, sum_d;
  logic                   ovf_q, ovf_d;
  logic                   stb_q, stb_d;
  logic                   ack_q, ack_d;

  logic signed [aw-1:0]   term;
  logic signed [aw-1:0]   next_sum;
  logic                   next_ovf;
  logic                   xfer;

  // Datapath for one add: extended term, wrapped sum and its overflow bit.
  always_comb begin
    term     = sext_term(input_z);
    next_sum = acc_q + term;
    next_ovf = add_ovf(acc_q, term, next_sum);
  end

  // Next-state logic: accumulate in ACCUM, hold the result in OUTPUT until acknowledged.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    stb_d     = stb_q;
    ack_d     = ack_q;
    xfer      = 1'b0;

    unique case (state_q)
      ST_ACCUM: begin
        // ack is low for the first cycle after reset, so xfer is gated by it
        ack_d = 1'b1;
        stb_d = 1'b0;
        xfer  = input_z_stb && ack_q;
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            sum_d     = next_sum;
            ovf_d     = ovf_acc_q | next_ovf;
            stb_d     = 1'b1;
            ack_d     = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            state_d   = ST_OUTPUT;
          end else begin
            acc_d     = next_sum;
            cnt_d     = cnt_q + CNT_ONE;
            ovf_acc_d = ovf_acc_q | next_ovf;
          end
        end
      end

      ST_OUTPUT: begin
        // input side is stalled; sum and ovf are held until the next load
        ack_d = 1'b0;
        if (output_sum_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
        ack_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial group and any pending result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      stb_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      stb_q     <= stb_d;
      ack_q     <= ack_d;
    end
  end

  assign input_z_ack    = ack_q;
  assign output_sum     = sum_q;
  assign output_sum_stb = stb_q;
  assign output_ovf     = ovf_q;

endmodule
